// File: rtl/fft_frame_if.sv
// fft_frame_if: sample input, result output, working-RAM and core handshake signals of the FFT frame controller
interface fft_frame_if #(
    parameter int N_SAMPLES = 8,
    parameter int DATA_SIZE = 16
);
    localparam int AW = $clog2(N_SAMPLES);
    logic                 in_valid;
    logic [DATA_SIZE-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_ready;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;
    logic                 fft_start;
    logic                 fft_finish;
    logic                 busy;
    logic [31:0]          frame_cycles;
    modport master (
        input  in_valid, in_data, out_ready, mem_rdata, fft_finish,
        output in_ready, out_valid, out_data, mem_we, mem_addr, mem_wdata, fft_start, busy, frame_cycles
    );
    modport slave (
        output in_valid, in_data, out_ready, mem_rdata, fft_finish,
        input  in_ready, out_valid, out_data, mem_we, mem_addr, mem_wdata, fft_start, busy, frame_cycles
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: loads a frame into the FFT RAM, runs the core, streams results out; FFT_BITREV_LOAD_EN selects bit-reversed load addressing
module fft_frame_ctrl #(
    parameter int N_SAMPLES = 8,
    parameter int DATA_SIZE = 16
) (
    input logic clk,
    input logic rst,
    fft_frame_if.master bus
);
    localparam int AW = $clog2(N_SAMPLES);
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, UNLOAD} state_t;
    state_t state, state_nx;
    logic [AW-1:0] ld_idx, out_cnt, wr_addr;
    logic [AW:0] rd_cnt;
    logic [31:0] run_cnt;
    logic pend, skid_valid, accept, fire, rd_issue;
    logic [DATA_SIZE-1:0] skid_data;
    logic [1:0] occ;
`ifdef FFT_BITREV_LOAD_EN
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        for (int i = 0; i < AW; i++) bitrev[i] = v[AW-1-i];
    endfunction
    assign wr_addr = bitrev(ld_idx);
`else
    assign wr_addr = ld_idx;
`endif
    assign bus.in_ready  = state == IDLE || state == LOAD;
    assign accept        = bus.in_valid && bus.in_ready;
    assign fire          = bus.out_valid && bus.out_ready;
    // occupancy counts the output register, the skid slot and the read in flight
    assign occ           = 2'(bus.out_valid) + 2'(skid_valid) + 2'(pend);
    assign rd_issue      = state == UNLOAD && !rd_cnt[AW] && (!bus.out_valid || bus.out_ready) && (occ - 2'(fire)) < 2'd2;
    assign bus.mem_we    = accept;
    assign bus.mem_wdata = accept ? bus.in_data : '0;
    assign bus.mem_addr  = accept ? wr_addr : rd_issue ? rd_cnt[AW-1:0] : '0;
    assign bus.fft_start = state == START;
    assign bus.busy      = state != IDLE;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next-state: load N samples, pulse start, wait for the core, drain N results
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? LOAD : IDLE;
            LOAD:    state_nx = (accept && ld_idx == AW'(N_SAMPLES-1)) ? START : LOAD;
            START:   state_nx = RUN;
            RUN:     state_nx = bus.fft_finish ? UNLOAD : RUN;
            UNLOAD:  state_nx = (fire && out_cnt == AW'(N_SAMPLES-1)) ? IDLE : UNLOAD;
            default: state_nx = IDLE;
        endcase
    end
    // counters, run-length capture and the registered read path with a one-entry skid slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_idx           <= '0;
            out_cnt          <= '0;
            rd_cnt           <= '0;
            run_cnt          <= '0;
            pend             <= 1'b0;
            skid_valid       <= 1'b0;
            skid_data        <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.frame_cycles <= '0;
        end else begin
            if (accept) ld_idx <= ld_idx + 1'b1;
            if (fire) out_cnt <= out_cnt + 1'b1;
            run_cnt <= state == START ? '0 : state == RUN ? run_cnt + 1 : run_cnt;
            if (state == RUN && bus.fft_finish) bus.frame_cycles <= run_cnt + 1;
            rd_cnt <= (state == UNLOAD && state_nx == IDLE) ? '0 : rd_cnt + (AW+1)'(rd_issue);
            pend <= rd_issue;
            if (!bus.out_valid || fire) begin
                bus.out_valid <= skid_valid || pend;
                if (skid_valid || pend) bus.out_data <= skid_valid ? skid_data : bus.mem_rdata;
                skid_valid <= skid_valid && pend;
                if (pend) skid_data <= bus.mem_rdata;
            end else if (pend) begin
                skid_valid <= 1'b1;
                skid_data  <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: frame-level model and directed frames for fft_frame_ctrl
module tb_fft_frame_ctrl;
    localparam int N = 8;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fft_frame_if #(.N_SAMPLES(N), .DATA_SIZE(DW)) bus();
    fft_frame_ctrl #(.N_SAMPLES(N), .DATA_SIZE(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
    // RAM stand-in: read data is address + 0x100, one cycle after the address
    always @(posedge clk) bus.mem_rdata <= 16'h100 + 16'(bus.mem_addr);
`ifdef FFT_BITREV_LOAD_EN
    int addr_tab [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    int addr_tab [N] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n_cmp = 0;
    int n_err = 0;
    int wcnt, ocnt, total_hs, cyc, start_cyc;
    bit start_due, started, unl, prev_stall, wr;
    logic [DW-1:0] prev_data;
    logic [31:0] exp_fc;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask
    // frame model: N writes in order, start the cycle after the last one, N results 0x100+i, then idle
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            wcnt = 0; ocnt = 0; start_due = 0; started = 0; unl = 0; prev_stall = 0; exp_fc = 0;
        end else begin
            wr = bus.in_valid && wcnt < N;
            chk("in_ready", bus.in_ready, wcnt < N);
            chk("busy", bus.busy, wcnt != 0);
            chk("fft_start", bus.fft_start, start_due);
            chk("mem_we", bus.mem_we, wr);
            chk("frame_cycles", bus.frame_cycles, exp_fc);
            if (!unl) chk("out_valid_early", bus.out_valid, 0);
            if (wr) begin
                chk("wr_addr", bus.mem_addr, addr_tab[wcnt]);
                chk("wr_data", bus.mem_wdata, bus.in_data);
            end else if (!unl) chk("addr_idle", bus.mem_addr, 0);
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
            end
            if (started && !unl && bus.fft_finish) begin
                unl = 1;
                exp_fc = cyc - start_cyc;
            end
            if (bus.fft_start) begin
                started = 1;
                start_cyc = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("out_data", bus.out_data, 32'h100 + ocnt);
                ocnt++;
                total_hs++;
                if (ocnt == N) begin
                    wcnt = 0; ocnt = 0; started = 0; unl = 0;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            start_due = wr && wcnt == N - 1;
            if (wr) wcnt++;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic load(input bit gaps);
        for (int k = 0; k < N; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'(k + 1);
            tick();
            if (gaps && k == 3) begin
                bus.in_valid = 1'b0;
                bus.fft_finish = 1'b1;
                repeat (3) tick();
                bus.fft_finish = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_start();
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.fft_start && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", bus.fft_start, 1);
    endtask
    task automatic finish_after(input int dly);
        tick();
        repeat (dly - 1) tick();
        bus.fft_finish = 1'b1;
        tick();
        bus.fft_finish = 1'b0;
        @(negedge clk);
        chk("frame_cycles_lit", bus.frame_cycles, dly);
    endtask
    task automatic unload_full();
        int t;
        t = 0;
        while (!bus.out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < N; i++) begin
            chk("stream_valid", bus.out_valid, 1);
            chk("stream_data", bus.out_data, 32'h100 + i);
            @(negedge clk);
        end
        chk("busy_after_stream", bus.busy, 0);
        chk("out_valid_after_stream", bus.out_valid, 0);
    endtask
    task automatic unload_toggle();
        int hs0, i;
        hs0 = total_hs;
        i = 0;
        tick();
        while (bus.busy && i < 100) begin
            bus.out_ready = pat[i % 4];
            tick();
            i++;
        end
        @(negedge clk);
        chk("handshakes", total_hs - hs0, N);
        chk("busy_after_toggle", bus.busy, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.fft_finish = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_fft_start", bus.fft_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_cycles", bus.frame_cycles, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", bus.in_ready, 1);
        tick();
        bus.fft_finish = 1'b1;
        tick();
        bus.fft_finish = 1'b0;
        bus.out_ready = 1'b1;
        load(1'b0);
        wait_start();
        finish_after(20);
        unload_full();
        tick();
        load(1'b1);
        wait_start();
        finish_after(5);
        unload_toggle();
        bus.out_ready = 1'b1;
        load(1'b0);
        wait_start();
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_fft_start", bus.fft_start, 0);
        chk("abort_frame_cycles", bus.frame_cycles, 0);
        chk("abort_mem_addr", bus.mem_addr, 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        load(1'b0);
        wait_start();
        finish_after(7);
        unload_full();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 8, meaning FFT points per frame (power of two, >=4).
REQ-002 SHALL have parameter DATA_SIZE, default 16, meaning sample/memory word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports in_valid input 1, in_data input DATA_SIZE, in_ready output 1: sample input stream.
REQ-006 SHALL have ports out_valid output 1, out_data output DATA_SIZE, out_ready input 1: result output stream.
REQ-007 SHALL have ports mem_we output 1, mem_addr output $clog2(N_SAMPLES), mem_wdata output DATA_SIZE, mem_rdata input DATA_SIZE: port into the FFT working RAM; read data valid one cycle after address.
REQ-008 SHALL have ports fft_start output 1 and fft_finish input 1: handshake to the FFT core.
REQ-009 SHALL have ports busy output 1 (state != IDLE) and frame_cycles output 32 (core run length of last frame).

Function
REQ-010 SHALL implement states IDLE, LOAD, START, RUN, UNLOAD.
REQ-011 IDLE: in_ready=1; first accepted sample (in_valid&in_ready) SHALL be written at load index 0 and move to LOAD.
REQ-012 LOAD: in_ready=1; each accepted sample written same cycle (mem_we=1, mem_wdata=in_data) at the next load index; after sample N_SAMPLES-1 accepted, go to START.
REQ-013 in_valid low in LOAD SHALL stall without writes; index holds.
REQ-014 START: fft_start=1 for exactly one cycle, then RUN; in_ready=0 in START/RUN/UNLOAD.
REQ-015 RUN: mem_we=0; counter increments each cycle from 0 (START cycle clears it); on fft_finish=1 latch counter into frame_cycles and go to UNLOAD.
REQ-016 fft_finish SHALL be ignored in every state except RUN.
REQ-017 UNLOAD: read address r issued (mem_addr=r, r from 0 upward, natural order) when r<N_SAMPLES and (!out_valid or out_ready); out_data/out_valid registered from mem_rdata the following cycle.
REQ-018 out_valid SHALL hold with out_data stable while out_ready=0; no read issued then.
REQ-019 After the N_SAMPLES-th output handshake, go to IDLE with out_valid=0; sustained out_ready=1 SHALL give one result per cycle.
REQ-020 mem_addr SHALL be 0 whenever no write or read is issued; index counters wrap modulo N_SAMPLES.
REQ-021 Back-to-back frames: a sample presented in the IDLE cycle after UNLOAD completes SHALL be accepted.

Reset
REQ-022 On rst: state=IDLE, in_ready=1 after release, out_valid=0, out_data=0, mem_we=0, mem_addr=0, mem_wdata=0, fft_start=0, busy=0, frame_cycles=0, all counters 0.
REQ-023 rst asserted mid-frame (any state) SHALL abort immediately; the partial frame is discarded, no pulse on fft_start after release.

Configuration
REQ-024 With macro FFT_BITREV_LOAD_EN defined, LOAD SHALL write sample k at bit-reversed address of k (log2(N_SAMPLES) bits); without it, at address k.
REQ-025 UNLOAD order SHALL be natural in both configurations.

Verification
REQ-026 Reset then 8 samples 1..8 with in_valid continuous -> writes at addr 0..7 (macro off) or 0,4,2,6,1,5,3,7 (macro on); fft_start one-cycle pulse the cycle after last write.
REQ-027 fft_finish pulsed 20 cycles after fft_start -> frame_cycles=20, UNLOAD entered, fft_finish during LOAD/IDLE has no effect.
REQ-028 mem_rdata=addr+0x100 model, out_ready=1 -> out_data 0x100..0x107 on 8 consecutive cycles, then busy=0.
REQ-029 out_ready toggled 1,0,0,1 pattern -> no dropped or repeated output; out_data stable while stalled; exactly 8 handshakes.
REQ-030 in_valid gaps during LOAD (3 idle cycles after sample 4) -> no writes in gaps, fft_start only after 8th sample.
REQ-031 rst asserted in RUN for one cycle -> all outputs at reset values, busy=0, next frame loads from index 0 normally.
